// File: rtl/pwm_envelope_decoder.sv
// PWM period/high-time meter for the jump sound loopback path.
// Optional duty ratio divider is built when DUTY_RATIO_EN is defined.
module pwm_envelope_decoder #(
    parameter int CNT_W       = 19,
    parameter int TIMEOUT     = 400000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [4:0]       pulse_idx,
    output logic             active,
    output logic             timeout
`ifdef DUTY_RATIO_EN
    ,
    output logic [7:0]       duty_q8,
    output logic             duty_valid,
    output logic             duty_busy
`endif
);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;
    logic [CNT_W-1:0]       hcnt, pcnt;
    logic [4:0]             idx;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hcnt       <= '0;
            pcnt       <= '0;
            idx        <= '0;
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            period_cnt <= '0;
            pulse_idx  <= '0;
            active     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= HIGH;
                        hcnt   <= ONE;
                        pcnt   <= ONE;
                        idx    <= '0;
                        active <= 1'b1;
                    end
                end
                HIGH: begin
                    if (pcnt == TO_VAL && !rise) begin
                        state   <= IDLE;
                        hcnt    <= '0;
                        pcnt    <= '0;
                        idx     <= '0;
                        active  <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        pcnt <= sat_inc(pcnt);
                        if (fall) state <= LOW;
                        else if (s) hcnt <= sat_inc(hcnt);
                    end
                end
                LOW: begin
                    // A rise closes the period; the rise cycle belongs to the next one.
                    if (rise) begin
                        meas_valid <= 1'b1;
                        high_cnt   <= hcnt;
                        period_cnt <= pcnt;
                        pulse_idx  <= idx;
                        hcnt       <= ONE;
                        pcnt       <= ONE;
                        idx        <= (idx == 5'd31) ? idx : idx + 5'd1;
                        state      <= HIGH;
                    end else if (pcnt == TO_VAL) begin
                        state   <= IDLE;
                        hcnt    <= '0;
                        pcnt    <= '0;
                        idx     <= '0;
                        active  <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        pcnt <= sat_inc(pcnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DUTY_RATIO_EN
    // Restoring long division of high_cnt/period_cnt for 8 fraction bits.
    logic [CNT_W-1:0] rem;
    logic [CNT_W:0]   rem2, trial;
    logic             ge;
    logic [7:0]       quo;
    logic [2:0]       step;

    assign rem2  = {rem, 1'b0};
    assign ge    = rem2 >= {1'b0, period_cnt};
    assign trial = rem2 - {1'b0, period_cnt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem        <= '0;
            quo        <= '0;
            step       <= '0;
            duty_q8    <= '0;
            duty_valid <= 1'b0;
            duty_busy  <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (meas_valid) begin
                rem       <= high_cnt;
                quo       <= '0;
                step      <= '0;
                duty_busy <= 1'b1;
            end else if (duty_busy) begin
                rem  <= ge ? trial[CNT_W-1:0] : rem2[CNT_W-1:0];
                quo  <= {quo[6:0], ge};
                step <= step + 3'd1;
                if (step == 3'd7) begin
                    duty_busy  <= 1'b0;
                    duty_valid <= 1'b1;
                    duty_q8    <= {quo[6:0], ge};
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_pwm_envelope_decoder.sv
// Self-checking bench for pwm_envelope_decoder: table-driven bursts plus
// hand sequences, scoreboard of expected measurements. Duty checks under DUTY_RATIO_EN.
module tb_pwm_envelope_decoder;
    localparam int CNT_W = 19;
    localparam int TO    = 4000;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic [4:0]       pulse_idx;
    logic             active, timeout;
`ifdef DUTY_RATIO_EN
    logic [7:0]       duty_q8;
    logic             duty_valid, duty_busy;
`endif

    pwm_envelope_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
        .meas_valid(meas_valid), .high_cnt(high_cnt), .period_cnt(period_cnt),
        .pulse_idx(pulse_idx), .active(active), .timeout(timeout)
`ifdef DUTY_RATIO_EN
        , .duty_q8(duty_q8), .duty_valid(duty_valid), .duty_busy(duty_busy)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {int h; int p; int idx;} exp_t;
    typedef struct {int h; int l; int exp_h; int exp_p; int tail;} vec_t;

    exp_t sbq[$];
    int   n_chk = 0, n_fail = 0;
    int   mv_count = 0, to_count = 0, dv_count = 0, mv_age = 0, exp_duty = 0;
    int   idx_model = 0, prev_h = 0, prev_p = 0;
    bit   have_prev = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each measurement.
    always @(negedge clk) begin
        exp_t e;
        mv_age++;
`ifdef DUTY_RATIO_EN
        if (duty_valid) begin
            dv_count++;
            chk("duty_latency", mv_age, 9);
            chk("duty_q8", duty_q8, exp_duty);
        end
`endif
        if (meas_valid || timeout) chk("meas_timeout_overlap", meas_valid & timeout, 0);
        if (meas_valid) begin
            mv_count++;
            mv_age = 0;
            if (sbq.size() == 0) chk("unexpected_meas_valid", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("high_cnt", high_cnt, e.h);
                chk("period_cnt", period_cnt, e.p);
                chk("pulse_idx", pulse_idx, e.idx);
                exp_duty = e.h * 256 / e.p;
            end
        end
        if (timeout) to_count++;
    end

    task automatic push_prev();
        if (have_prev) begin
            sbq.push_back('{prev_h, prev_p, idx_model});
            if (idx_model < 31) idx_model++;
        end
    endtask

    task automatic send_period(input int h, input int l, input int eh, input int ep);
        push_prev();
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
        have_prev = 1;
        prev_h = eh;
        prev_p = ep;
    endtask

    task automatic final_rise();
        push_prev();
        have_prev = 0;
        pwm_in = 1'b1;
        @(negedge clk);
        pwm_in = 1'b0;
    endtask

    task automatic end_burst();
        int to0;
        bit seen;
        to0 = to_count;
        seen = 0;
        pwm_in = 1'b0;
        for (int c = 0; c < TO + 100; c++) begin
            @(negedge clk);
            if (timeout) begin
                seen = 1;
                break;
            end
        end
        chk("timeout_seen", seen, 1);
        chk("active_after_timeout", active, 0);
        @(negedge clk);
        chk("timeout_pulse_width", timeout, 0);
        chk("timeout_count", to_count - to0, 1);
        chk("scoreboard_drained", sbq.size(), 0);
        have_prev = 0;
        idx_model = 0;
    endtask

    initial begin
        vec_t vecs[9];
        int   mv0, to0, dv0, lat, tcyc;
        vecs[0] = '{100, 200, 100, 300, 0};
        vecs[1] = '{100, 200, 100, 300, 0};
        vecs[2] = '{100, 200, 100, 300, 1};
        vecs[3] = '{1667, 1667, 1667, 3334, 0};
        vecs[4] = '{1405, 1929, 1405, 3334, 0};
        vecs[5] = '{1183, 2151, 1183, 3334, 2};
        vecs[6] = '{1, 1, 1, 2, 0};
        vecs[7] = '{1, 1, 1, 2, 0};
        vecs[8] = '{3, 5, 3, 8, 2};

        rst_n = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_meas_valid", meas_valid, 0);
        chk("rst_high_cnt", high_cnt, 0);
        chk("rst_period_cnt", period_cnt, 0);
        chk("rst_pulse_idx", pulse_idx, 0);
        chk("rst_active", active, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        repeat (1000) @(negedge clk);
        chk("idle_active", active, 0);
        chk("idle_meas_count", mv_count, 0);
        chk("idle_timeout_count", to_count, 0);
        chk("idle_high_cnt", high_cnt, 0);
        chk("idle_period_cnt", period_cnt, 0);

        foreach (vecs[i]) begin
            send_period(vecs[i].h, vecs[i].l, vecs[i].exp_h, vecs[i].exp_p);
            if (vecs[i].tail == 2) final_rise();
            if (vecs[i].tail != 0) end_burst();
        end

        // Second measurement 4 cycles after the first restarts the divider.
        dv0 = dv_count;
        send_period(100, 200, 100, 300);
        send_period(2, 2, 2, 4);
        final_rise();
        end_burst();
`ifdef DUTY_RATIO_EN
        chk("duty_abort_count", dv_count - dv0, 1);
        chk("duty_abort_value", exp_duty, 128);
`endif

        // Stuck high, including high at reset exit.
        rst_n = 1'b0;
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        mv0 = mv_count;
        to0 = to_count;
        rst_n = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (active) begin
                lat = c;
                break;
            end
        end
        chk("active_latency_edges", lat, SS + 1);
        tcyc = -1;
        for (int c = 1; c <= TO + 100; c++) begin
            @(negedge clk);
            if (timeout) begin
                tcyc = c;
                break;
            end
        end
        chk("stuck_timeout_cycle", tcyc, TO);
        chk("stuck_active_low", active, 0);
        repeat (1000) @(negedge clk);
        chk("stuck_timeout_count", to_count - to0, 1);
        chk("stuck_no_meas", mv_count - mv0, 0);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);

        // Index saturation, then reset mid-period.
        for (int k = 0; k < 40; k++) send_period(10, 10, 10, 20);
        push_prev();
        have_prev = 0;
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("sat_scoreboard_drained", sbq.size(), 0);
        chk("sat_last_idx", pulse_idx, 31);
        pwm_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idx_model = 0;
        @(negedge clk);
        chk("post_reset_active", active, 0);
        send_period(10, 10, 10, 20);
        send_period(10, 10, 10, 20);
        final_rise();
        end_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
